// File: rtl/aes_subword_arbiter.sv
// aes_subword_arbiter
// Time-shares one 32-bit SubWord unit between the round datapath (128-bit
// state, issued as four words w0..w3) and the key scheduler (one word).
// Only one transaction is in flight at a time. Results come back through a
// tag pipeline that mirrors the unit latency, so a result is captured only
// when a matching tag arrives.
module aes_subword_arbiter #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_data,
  output logic         st_res_valid,
  output logic [127:0] st_res_data,
  input  logic         ks_valid,
  output logic         ks_ready,
  input  logic [31:0]  ks_word,
  output logic         ks_res_valid,
  output logic [31:0]  ks_res_word,
  output logic [31:0]  sb_in,
  output logic         sb_in_valid,
  input  logic [31:0]  sb_out,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, ST_ISSUE, ST_WAIT, KS_ISSUE, KS_WAIT} state_t;

  state_t               state, state_nxt;
  logic                 last_st;     // 1: last accepted requester was the state path
  logic [1:0]           iss_cnt;
  logic [1:0]           col_cnt;
  logic [127:0]         st_cap;
  logic [95:0]          shadow;      // words 0..2 of a result being collected
  logic [31:0]          ks_cap;
  logic [SBOX_LAT-1:0]  tag_vld;
  logic [SBOX_LAT-1:0]  tag_ks;
  logic                 gnt_st, gnt_ks;

  // Round-robin on ties: the requester that did not win last time goes first
  assign gnt_st = st_valid & (~ks_valid | ~last_st);
  assign gnt_ks = ks_valid & (~st_valid | last_st);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: issue phase, then wait for the result pulse before idling
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (gnt_st)            state_nxt = ST_ISSUE;
                else if (gnt_ks)       state_nxt = KS_ISSUE;
      ST_ISSUE: if (iss_cnt == 2'd3)   state_nxt = ST_WAIT;
      ST_WAIT:  if (st_res_valid)      state_nxt = IDLE;
      KS_ISSUE:                        state_nxt = KS_WAIT;
      KS_WAIT:  if (ks_res_valid)      state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: handshakes, SubWord drive, busy
  always_comb begin
    st_ready    = 1'b0;
    ks_ready    = 1'b0;
    sb_in       = 32'd0;
    sb_in_valid = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        // rst_n gate keeps ready low while reset is held
        st_ready = rst_n & gnt_st;
        ks_ready = rst_n & gnt_ks;
      end
      ST_ISSUE: begin
        sb_in       = st_cap[{iss_cnt, 5'd0} +: 32];
        sb_in_valid = 1'b1;
      end
      KS_ISSUE: begin
        sb_in       = ks_cap;
        sb_in_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture request data on accept and remember who won
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_cap  <= '0;
      ks_cap  <= '0;
      last_st <= 1'b1;
    end else if (st_ready) begin
      st_cap  <= st_data;
      last_st <= 1'b1;
    end else if (ks_ready) begin
      ks_cap  <= ks_word;
      last_st <= 1'b0;
    end
  end

  // Issue counter walks w0..w3 and wraps back to 0 for the next request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 iss_cnt <= 2'd0;
    else if (state == ST_ISSUE) iss_cnt <= iss_cnt + 2'd1;
  end

  // Tag pipeline, SBOX_LAT deep, aligned with the SubWord unit output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_ks  <= '0;
    end else begin
      tag_vld[0] <= sb_in_valid;
      tag_ks[0]  <= (state == KS_ISSUE);
      for (int i = 1; i < SBOX_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_ks[i]  <= tag_ks[i-1];
      end
    end
  end

  // Collect results; state words go to the shadow until word 3 completes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt      <= 2'd0;
      shadow       <= '0;
      st_res_data  <= '0;
      st_res_valid <= 1'b0;
      ks_res_word  <= '0;
      ks_res_valid <= 1'b0;
    end else begin
      st_res_valid <= 1'b0;
      ks_res_valid <= 1'b0;
      if (tag_vld[SBOX_LAT-1]) begin
        if (tag_ks[SBOX_LAT-1]) begin
          ks_res_word  <= sb_out;
          ks_res_valid <= 1'b1;
        end else begin
          col_cnt <= col_cnt + 2'd1;
          case (col_cnt)
            2'd0: shadow[31:0]  <= sb_out;
            2'd1: shadow[63:32] <= sb_out;
            2'd2: shadow[95:64] <= sb_out;
            default: begin
              st_res_data  <= {sb_out, shadow};
              st_res_valid <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule
